// File: rtl/axi_dma_rd_mo.sv
// axi_dma_rd_mo: multi-outstanding AXI4 read DMA with credit-gated AR issue and FWFT output FIFO.
// Optional perf counters enabled by defining AXI_DMA_RD_PERF_EN.
module axi_dma_rd_mo #(
  parameter int BITS_TRANS      = 18,
  parameter int AXI_WIDTH_ID    = 4,
  parameter int AXI_WIDTH_AD    = 32,
  parameter int AXI_WIDTH_DA    = 64,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
  output logic [AXI_WIDTH_ID-1:0] M_ARID,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic [3:0]              M_ARCACHE,
  output logic [2:0]              M_ARPROT,
  output logic [3:0]              M_ARQOS,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
  input  logic                    M_RLAST,
  input  logic [1:0]              M_RRESP,
  input  logic                    start_dma,
  input  logic [BITS_TRANS-1:0]   num_trans,
  input  logic [AXI_WIDTH_AD-1:0] start_addr,
  output logic [AXI_WIDTH_DA-1:0] data_o,
  output logic                    data_vld_o,
  input  logic                    data_rdy_i,
  output logic [BITS_TRANS-1:0]   data_cnt_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    busy_o
`ifdef AXI_DMA_RD_PERF_EN
  ,
  output logic [31:0]             perf_busy_cyc_o,
  output logic [31:0]             perf_stall_cyc_o
`endif
);
  localparam int SZ = $clog2(AXI_WIDTH_DA / 8);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [2:0] {IDLE, CALC, ADDR, DRAIN, DONE} state_t;
  state_t                  state;
  logic [AXI_WIDTH_AD-1:0] addr;
  logic [BITS_TRANS-1:0]   rem_issue, ntrans;
  logic [7:0]              arlen;
  logic [OW-1:0]           out_cnt;
  logic [CW-1:0]           count, reserved;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AXI_WIDTH_DA-1:0] mem [FIFO_DEPTH];
  logic [12:0]             bnd_w;
  logic [8:0]              b_len, len_n, len9;
  logic                    push, pop, ar_hs, can_issue, last_pop;
  assign M_ARADDR   = addr;
  assign M_ARLEN    = arlen;
  assign M_ARID     = '0;
  assign M_ARSIZE   = 3'(SZ);
  assign M_ARBURST  = 2'b01;
  assign M_ARCACHE  = 4'd0;
  assign M_ARPROT   = 3'd0;
  assign M_ARQOS    = 4'b1111;
  assign M_RREADY   = busy_o && count != CW'(FIFO_DEPTH);
  assign data_vld_o = count != '0;
  assign data_o     = data_vld_o ? mem[rd_ptr] : '0;
  always_comb begin
    bnd_w     = (13'h1000 - {1'b0, addr[11:0]}) >> SZ;
    b_len     = rem_issue < BITS_TRANS'(MAX_BURST) ? 9'(rem_issue) : 9'(MAX_BURST);
    len_n     = {4'b0, b_len} > bnd_w ? 9'(bnd_w) : b_len;
    len9      = {1'b0, arlen} + 9'd1;
    push      = M_RVALID && M_RREADY;
    pop       = data_vld_o && data_rdy_i;
    ar_hs     = M_ARVALID && M_ARREADY;
    // credit counts both stored words and words promised to already-issued bursts
    can_issue = 32'(out_cnt) < MAX_OUTSTANDING &&
                32'(CW'(FIFO_DEPTH) - count - reserved) >= 32'(len9);
    last_pop  = data_cnt_o == ntrans || (pop && data_cnt_o + BITS_TRANS'(1) == ntrans);
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= M_RDATA;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      addr       <= '0;
      rem_issue  <= '0;
      ntrans     <= '0;
      arlen      <= '0;
      out_cnt    <= '0;
      count      <= '0;
      reserved   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      M_ARVALID  <= 1'b0;
      data_cnt_o <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      count    <= count + CW'(push) - CW'(pop);
      reserved <= reserved + (ar_hs ? CW'(len9) : CW'(0)) - CW'(push);
      out_cnt  <= out_cnt + OW'(ar_hs) - OW'(push && M_RLAST);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (push && M_RRESP != 2'b00) err_o <= 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        data_cnt_o <= data_cnt_o + BITS_TRANS'(1);
      end
      case (state)
        IDLE: if (start_dma) begin
          ntrans     <= num_trans;
          rem_issue  <= num_trans;
          addr       <= start_addr & ~AXI_WIDTH_AD'((1 << SZ) - 1);
          err_o      <= 1'b0;
          data_cnt_o <= '0;
          busy_o     <= 1'b1;
          state      <= CALC;
        end
        CALC: begin
          arlen <= rem_issue == '0 ? 8'd0 : 8'(len_n - 9'd1);
          state <= rem_issue == '0 ? DRAIN : ADDR;
        end
        ADDR: if (ar_hs) begin
          M_ARVALID <= 1'b0;
          rem_issue <= rem_issue - BITS_TRANS'(len9);
          addr      <= addr + (AXI_WIDTH_AD'(len9) << SZ);
          state     <= CALC;
        end else if (can_issue) M_ARVALID <= 1'b1;
        DRAIN: if (last_pop) begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXI_DMA_RD_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cyc_o  <= '0;
      perf_stall_cyc_o <= '0;
    end else if (state == IDLE && start_dma) begin
      perf_busy_cyc_o  <= '0;
      perf_stall_cyc_o <= '0;
    end else begin
      if (busy_o && ~&perf_busy_cyc_o) perf_busy_cyc_o <= perf_busy_cyc_o + 32'd1;
      if (state == ADDR && !M_ARVALID && !can_issue && ~&perf_stall_cyc_o)
        perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_dma_rd_mo.sv
// tb_axi_dma_rd_mo: directed bench with an AXI read slave model and an output-word monitor.
module tb_axi_dma_rd_mo;
  logic        clk, rstn;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
  logic [31:0] M_ARADDR;
  logic [3:0]  M_ARID, M_ARCACHE, M_ARQOS;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE, M_ARPROT;
  logic [1:0]  M_ARBURST, M_RRESP;
  logic [63:0] M_RDATA, data_o;
  logic        start_dma, data_vld_o, data_rdy_i, done_o, err_o, busy_o;
  logic [17:0] num_trans, data_cnt_o;
  logic [31:0] start_addr;
  int n_chk = 0, n_err = 0;
  int cyc = 0, pop_idx = 0, done_cnt = 0, tbeat = 0, beat = 0, first_rlast = -1, err_beat = -1;
  bit r_en, r_hs, ar_hs, rr_drop;
  logic [63:0] base;
  typedef struct {logic [31:0] a; logic [7:0] l;} ar_t;
  ar_t q[$];
  ar_t pend;
  logic [31:0] log_a[$];
  logic [7:0]  log_l[$];
  int          log_cyc[$];

  axi_dma_rd_mo #(.BITS_TRANS(18), .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(64),
                  .MAX_BURST(64), .MAX_OUTSTANDING(4), .FIFO_DEPTH(256)) dut (
    .clk(clk), .rstn(rstn), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
    .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_RVALID(M_RVALID),
    .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RLAST(M_RLAST), .M_RRESP(M_RRESP),
    .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr), .data_o(data_o),
    .data_vld_o(data_vld_o), .data_rdy_i(data_rdy_i), .data_cnt_o(data_cnt_o), .done_o(done_o),
    .err_o(err_o), .busy_o(busy_o));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // read slave: data word = word address, so every output word is predictable
  initial begin
    M_RVALID = 0; M_RLAST = 0; M_RRESP = 0; M_RDATA = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        q.delete(); r_hs = 0; ar_hs = 0; beat = 0; M_RVALID = 0;
      end else begin
        if (start_dma && !busy_o) begin
          log_a.delete(); log_l.delete(); log_cyc.delete(); tbeat = 0; first_rlast = -1;
        end
        if (r_hs) begin
          if (tbeat == err_beat) check("err_set", 64'(err_o), 1);
          if (M_RLAST) begin
            void'(q.pop_front()); beat = 0;
            if (first_rlast < 0) first_rlast = cyc;
          end else beat++;
          tbeat++;
        end
        if (ar_hs) q.push_back(pend);
        M_RVALID = r_en && q.size() > 0;
        if (M_RVALID) begin
          M_RDATA = 64'(q[0].a >> 3) + 64'(beat);
          M_RLAST = beat == int'(q[0].l);
          M_RRESP = tbeat == err_beat ? 2'b10 : 2'b00;
        end else begin
          M_RLAST = 0; M_RRESP = 0;
        end
        r_hs = M_RVALID && M_RREADY;
        if (r_hs && tbeat == err_beat) check("err_pre", 64'(err_o), 0);
        if (M_RVALID && !M_RREADY) rr_drop = 1;
        ar_hs = M_ARVALID && M_ARREADY;
        if (ar_hs) begin
          pend = '{M_ARADDR, M_ARLEN};
          log_a.push_back(M_ARADDR); log_l.push_back(M_ARLEN); log_cyc.push_back(cyc);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn && start_dma && !busy_o) begin
      pop_idx = 0; done_cnt = 0; base = 64'(start_addr >> 3);
    end
    if (done_o) done_cnt++;
    if (data_vld_o && data_rdy_i) begin
      check("data", data_o, base + 64'(pop_idx));
      check("data_cnt", 64'(data_cnt_o), 64'(pop_idx));
      pop_idx++;
    end
  end

  task automatic start(input logic [31:0] a, input logic [17:0] n);
    @(posedge clk); #1;
    start_addr = a; num_trans = n; start_dma = 1;
    @(posedge clk); #1;
    start_dma = 0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(negedge clk); n++;
    end
    check("done_seen", 64'(done_cnt > 0), 1);
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_cnt), 1);
    check("busy_end", 64'(busy_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    logic [31:0] ea[4];
    rstn = 0; start_dma = 0; num_trans = 0; start_addr = 0;
    M_ARREADY = 1; data_rdy_i = 1; r_en = 1; rr_drop = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_arvalid", 64'(M_ARVALID), 0);
    check("rst_araddr", 64'(M_ARADDR), 0);
    check("rst_arlen", 64'(M_ARLEN), 0);
    check("rst_rready", 64'(M_RREADY), 0);
    check("rst_vld", 64'(data_vld_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_err", 64'(err_o), 0);
    check("rst_cnt", 64'(data_cnt_o), 0);
    check("arsize", 64'(M_ARSIZE), 3);
    check("arburst", 64'(M_ARBURST), 1);
    check("arqos", 64'(M_ARQOS), 15);
    rstn = 1;
    // 200 words from 0x1000: three full bursts and a tail of 8
    start(32'h1000, 200);
    check("t1_busy", 64'(busy_o), 1);
    wait_done(3000);
    ea = '{32'h1000, 32'h1200, 32'h1400, 32'h1600};
    check("t1_ar_n", 64'(log_a.size()), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      check("t1_araddr", 64'(log_a[i]), 64'(ea[i]));
      check("t1_arlen", 64'(log_l[i]), i == 3 ? 7 : 63);
    end
    check("t1_pops", 64'(pop_idx), 200);
    check("t1_cnt", 64'(data_cnt_o), 200);
    check("t1_err", 64'(err_o), 0);
    // 4 KB boundary split
    start(32'h0FF0, 8);
    wait_done(500);
    check("t2_ar_n", 64'(log_a.size()), 2);
    if (log_a.size() == 2) begin
      check("t2_a0", 64'(log_a[0]), 64'h0FF0);
      check("t2_l0", 64'(log_l[0]), 1);
      check("t2_a1", 64'(log_a[1]), 64'h1000);
      check("t2_l1", 64'(log_l[1]), 5);
    end
    check("t2_pops", 64'(pop_idx), 8);
    // zero-length transfer
    start(32'h2000, 0);
    check("t3_busy", 64'(busy_o), 1);
    @(posedge clk); #1;
    check("t3_done_early", 64'(done_o), 0);
    @(posedge clk); #1;
    check("t3_done", 64'(done_o), 1);
    check("t3_busy_fall", 64'(busy_o), 0);
    check("t3_no_ar", 64'(log_a.size()), 0);
    repeat (3) @(posedge clk);
    // start while busy is ignored
    r_en = 0;
    start(32'h1000, 16);
    repeat (5) @(posedge clk); #1;
    start_addr = 32'h8000; num_trans = 5; start_dma = 1;
    @(posedge clk); #1;
    start_dma = 0;
    repeat (5) @(posedge clk); #1;
    r_en = 1;
    wait_done(500);
    check("t3_ign_n", 64'(log_a.size()), 1);
    if (log_a.size() > 0) begin
      check("t3_ign_a", 64'(log_a[0]), 64'h1000);
      check("t3_ign_l", 64'(log_l[0]), 15);
    end
    check("t3_ign_pops", 64'(pop_idx), 16);
    // outstanding limit with R channel stalled
    r_en = 0;
    start(32'h0, 1024);
    repeat (100) @(negedge clk);
    check("t4_ar_n", 64'(log_a.size()), 4);
    check("t4_arvalid", 64'(M_ARVALID), 0);
    r_en = 1;
    wait_done(6000);
    check("t4_ar_total", 64'(log_a.size()), 16);
    if (log_a.size() > 4) check("t4_5th_after_rlast", 64'(log_cyc[4] > first_rlast && first_rlast > 0), 1);
    check("t4_pops", 64'(pop_idx), 1024);
    // consumer backpressure
    data_rdy_i = 0;
    start(32'h4000, 512);
    repeat (800) @(negedge clk);
    sum = 0;
    foreach (log_l[i]) sum += int'(log_l[i]) + 1;
    check("t5_issued", 64'(sum), 256);
    check("t5_vld", 64'(data_vld_o), 1);
    check("t5_pops", 64'(pop_idx), 0);
    @(posedge clk); #1;
    data_rdy_i = 1;
    wait_done(3000);
    check("t5_pops_end", 64'(pop_idx), 512);
    check("t5_rready", 64'(rr_drop), 0);
    // error response on one beat
    err_beat = 5;
    start(32'h3000, 16);
    wait_done(500);
    check("t6_pops", 64'(pop_idx), 16);
    check("t6_err_sticky", 64'(err_o), 1);
    err_beat = -1;
    start(32'h3100, 4);
    check("t6_err_clr", 64'(err_o), 0);
    wait_done(500);
    check("t6_pops2", 64'(pop_idx), 4);
    check("t6_err_end", 64'(err_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi_dma_rd_mo.md
Name: axi_dma_rd_mo

Overview:
Parametrised multi-outstanding AXI4 read DMA that loads parameters and input feature maps from DRAM into the accelerator datapath.
- Generalises the single-burst read engine: configurable data width and burst length, 4 KB boundary splitting, and up to MAX_OUTSTANDING in-flight bursts.
- Adds an internal output FIFO with credit-based AR issue, so downstream backpressure (data_rdy_i) never stalls the R channel.
- Sits between the AXI interconnect master port and the layer buffer loaders.

Parameters:
BITS_TRANS, 18, width of the word count num_trans / data_cnt_o
AXI_WIDTH_ID, 4, ARID/RID width
AXI_WIDTH_AD, 32, address width
AXI_WIDTH_DA, 64, data width (32/64/128); one word = AXI_WIDTH_DA bits
MAX_BURST, 64, max beats per burst (power of 2, 1..256)
MAX_OUTSTANDING, 4, max issued-but-incomplete bursts (power of 2, ≥1)
FIFO_DEPTH, 256, output FIFO words (power of 2, ≥ MAX_BURST)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
M_ARVALID  out  1  AR valid
M_ARREADY  in  1  AR ready
M_ARADDR  out  AXI_WIDTH_AD  burst start address
M_ARID  out  AXI_WIDTH_ID  constant 0
M_ARLEN  out  8  beats-1
M_ARSIZE  out  3  log2(AXI_WIDTH_DA/8)
M_ARBURST  out  2  constant 2'b01 (INCR)
M_ARCACHE, M_ARPROT, M_ARQOS  out  4/3/4  constants 0, 0, 4'b1111
M_RVALID  in  1  R valid
M_RREADY  out  1  R ready
M_RDATA  in  AXI_WIDTH_DA  read data
M_RLAST  in  1  last beat
M_RRESP  in  2  response
start_dma  in  1  one-cycle start pulse
num_trans  in  BITS_TRANS  words to read
start_addr  in  AXI_WIDTH_AD  byte address
data_o  out  AXI_WIDTH_DA  output word (FIFO head)
data_vld_o  out  1  data_o valid
data_rdy_i  in  1  consumer ready
data_cnt_o  out  BITS_TRANS  index of word on data_o
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky error, any RRESP≠0
busy_o  out  1  high from accepted start to done_o

Behaviour:
- Reset values: all outputs 0, except M_ARSIZE, M_ARBURST, M_ARQOS, which are constants. FSM returns to IDLE and the FIFO and all counters are cleared. Reset mid-transfer abandons the transfer without waiting for outstanding R beats.
- Start:
  - start_dma is accepted only in IDLE; it is ignored while busy_o=1.
  - On acceptance, latch num_trans and start_addr with the low log2(AXI_WIDTH_DA/8) bits forced to 0. Clear err_o. busy_o=1 next cycle.
- FSM states:
  - IDLE → CALC on start.
  - CALC computes len = min(MAX_BURST, remaining_issue, words to next 4 KB boundary). Goes to ADDR if remaining_issue>0, else DRAIN.
  - ADDR holds M_ARVALID=1 until M_ARREADY, then decrements remaining_issue by len, advances the address by len*AXI_WIDTH_DA/8 bytes, and returns to CALC.
  - DRAIN waits until all words have been popped to the consumer, then goes to DONE.
  - DONE pulses done_o for 1 cycle, then goes to IDLE.
- Issue gating: ADDR raises M_ARVALID only when both hold:
  - outstanding < MAX_OUTSTANDING;
  - FIFO free slots minus reserved ≥ len.
  Reserved increments by len at AR handshake and decrements per beat written. Once asserted, ARVALID and its ARADDR/ARLEN stay stable until ARREADY.
- Outstanding count: increments on the AR handshake, decrements on an accepted RLAST beat; a same-cycle increment and decrement leaves it unchanged.
- R channel:
  - M_RREADY = FIFO not full (always true by credit; kept as a safety check).
  - Each RVALID&RREADY beat is written to the FIFO.
  - Beats with RRESP≠0 set err_o; the data is still forwarded. There is no retry.
- Output:
  - First-word fall-through FIFO: data_vld_o = FIFO not empty, data_o = FIFO head.
  - A pop occurs on data_vld_o&data_rdy_i.
  - data_cnt_o = number of pops since start (0 for the first word), incremented after each pop.
  - Simultaneous push and pop on a full FIFO is legal.
- Latency: first R beat appears on data_o 1 cycle after its handshake.
- num_trans=0: no AR is issued; done_o pulses 2 cycles after start.
- done_o is asserted in the cycle after the final pop. busy_o falls in the same cycle as done_o.

Optional Feature:
Macro AXI_DMA_RD_PERF_EN.
- When defined, the block adds output ports perf_busy_cyc_o (32b) and perf_stall_cyc_o (32b):
  - perf_busy_cyc_o counts cycles with busy_o=1.
  - perf_stall_cyc_o counts cycles in ADDR with ARVALID blocked by the outstanding limit or credit limit.
  - Both clear on accepted start and saturate at all-ones.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- AXI_WIDTH_DA=64, MAX_BURST=64, num_trans=200, start_addr=0x1000, ARREADY=1, data_rdy_i=1 → bursts ARLEN 63,63,63,7 at 0x1000,0x1200,0x1400,0x1600; 200 words with data_cnt_o 0..199 in order; one done_o pulse; err_o=0.
- start_addr=0x0FF0, num_trans=8, 64-bit → split into ARLEN 1 at 0x0FF0 and ARLEN 5 at 0x1000; data order preserved.
- Outstanding limit: RVALID held low, MAX_OUTSTANDING=4, num_trans=1024 → exactly 4 AR handshakes, then M_ARVALID=0 until the first RLAST.
- Backpressure: data_rdy_i=0, FIFO_DEPTH=256, num_trans=512 → at most 256 words issued (reserved+stored ≤256), M_RREADY never deasserted while RVALID=1; raising data_rdy_i completes all 512 words.
- RRESP=2'b10 on beat 5 of 16 → err_o=1 from the next cycle until the next start; all 16 words delivered; done_o pulses.
- num_trans=0 → no M_ARVALID, done_o 2 cycles after start; start_dma pulse while busy_o=1 → ignored, no change in ARADDR sequence.
